// File: rtl/serial_rx_param.sv
// Receiver for the bit-stuffed serial link. Detects a start bit after a zero gap, checks the stuff slots
// and the CRC, and publishes the payload and frame/error counts when a frame ends.
module serial_rx_param #(
  parameter int                 N_BYTES  = 8,
  parameter int                 CRC_W    = 16,
  parameter logic [CRC_W-1:0]   CRC_POLY = 16'h1021,
  parameter int                 GAP      = 9,
  parameter int                 CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic                   bit_in,
  output logic                   sync,
  output logic [8*N_BYTES-1:0]   d,
  output logic                   crc_err,
  output logic                   stuff_err,
  output logic [CNT_W-1:0]       frame_cnt,
  output logic [CNT_W-1:0]       err_cnt
);

  localparam int N_TOT  = N_BYTES + CRC_W / 8;
  localparam int BYTE_W = $clog2(N_TOT + 1);
  localparam int ZERO_W = $clog2(GAP + 1);
  localparam int PAY_W  = 8 * N_BYTES;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ZERO_W-1:0]   zero_cnt;
  logic [3:0]          bit_cnt;
  logic [BYTE_W-1:0]   byte_cnt;
  logic [CRC_W-1:0]    crc;
  logic [PAY_W-1:0]    sr;
  logic                start;
  logic                end_evt;
  logic                stuff_bad;
  logic                crc_bad;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    logic fb;
    fb = c[CRC_W-1] ^ b;
    return (c << 1) ^ (fb ? CRC_POLY : '0);
  endfunction

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    end_evt   = 1'b0;
    stuff_bad = 1'b0;
    crc_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (tick && bit_in && zero_cnt == ZERO_W'(GAP)) begin
          start     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (tick && bit_cnt == 4'd8) begin
          if (!bit_in) begin
            state_nxt = IDLE;
            end_evt   = 1'b1;
            stuff_bad = 1'b1;
          end else if (byte_cnt == BYTE_W'(N_TOT - 1)) begin
            // crc already holds the residue after the last data bit
            state_nxt = IDLE;
            end_evt   = 1'b1;
            crc_bad   = |crc;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      crc      <= '0;
      sr       <= '0;
    end else if (tick) begin
      if (bit_in) begin
        zero_cnt <= '0;
      end else if (zero_cnt != ZERO_W'(GAP)) begin
        zero_cnt <= zero_cnt + 1'b1;
      end
      if (start) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
        crc      <= '0;
      end else if (state == RUN) begin
        if (bit_cnt == 4'd8) begin
          bit_cnt  <= '0;
          byte_cnt <= byte_cnt + 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          crc     <= crc_step(crc, bit_in);
          if (byte_cnt < BYTE_W'(N_BYTES)) begin
            sr <= {bit_in, sr[PAY_W-1:1]};
          end
        end
      end
    end
  end

  // end-of-frame outputs, registered one clk after the ending tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= 1'b0;
      crc_err   <= 1'b0;
      stuff_err <= 1'b0;
      d         <= '0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      sync      <= end_evt;
      crc_err   <= crc_bad;
      stuff_err <= stuff_bad;
      if (end_evt) begin
        if (!crc_bad && !stuff_bad) begin
          d         <= sr;
          frame_cnt <= frame_cnt + 1'b1;
        end else if (err_cnt != '1) begin
          err_cnt <= err_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_param.sv
// Directed bench for serial_rx_param: a frame table on the default build (shared with a 2-bit-counter
// build), a mid-frame reset sequence, and one frame on a 4-byte / CRC-8 build.
module tb_serial_rx_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        bit_a = 1'b0;
  logic        bit_b = 1'b0;

  logic        sync0, crc_err0, stuff_err0;
  logic [63:0] d0;
  logic [15:0] fc0, ec0;
  logic        sync1, crc_err1, stuff_err1;
  logic [63:0] d1;
  logic [1:0]  fc1, ec1;
  logic        sync2, crc_err2, stuff_err2;
  logic [31:0] d2;
  logic [15:0] fc2, ec2;

  serial_rx_param dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .bit_in(bit_a), .sync(sync0), .d(d0),
    .crc_err(crc_err0), .stuff_err(stuff_err0), .frame_cnt(fc0), .err_cnt(ec0));

  serial_rx_param #(.CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .bit_in(bit_a), .sync(sync1), .d(d1),
    .crc_err(crc_err1), .stuff_err(stuff_err1), .frame_cnt(fc1), .err_cnt(ec1));

  serial_rx_param #(.N_BYTES(4), .CRC_W(8), .CRC_POLY(8'h07)) dut2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .bit_in(bit_b), .sync(sync2), .d(d2),
    .crc_err(crc_err2), .stuff_err(stuff_err2), .frame_cnt(fc2), .err_cnt(ec2));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pay;
    int          gap;
    int          flip;
    int          bad_stuff;
    bit          spaced;
    bit          exp_sync;
    bit          exp_crc;
    bit          exp_stuff;
    logic [63:0] exp_d;
    int          exp_fc;
    int          exp_ec;
  } vec_t;

  vec_t tbl [11];

  int   n_chk = 0;
  int   n_err = 0;
  int   pst = 0;
  time  edge_t [0:127];

  int          n_sync0 = 0, n_sync1 = 0, n_sync2 = 0, glitch = 0;
  time         t_sync0, t_sync2;
  logic        f_crc0, f_st0, f_crc2, f_st2;
  logic [63:0] d_at0;
  logic [31:0] d_at2;
  logic        prev0 = 1'b0, prev1 = 1'b0, prev2 = 1'b0;

  always @(negedge clk) begin
    if (sync0) begin
      n_sync0++; t_sync0 = $time; f_crc0 = crc_err0; f_st0 = stuff_err0; d_at0 = d0;
      if (prev0) glitch++;
    end else if (crc_err0 || stuff_err0) glitch++;
    if (sync1) begin
      n_sync1++;
      if (prev1) glitch++;
    end else if (crc_err1 || stuff_err1) glitch++;
    if (sync2) begin
      n_sync2++; t_sync2 = $time; f_crc2 = crc_err2; f_st2 = stuff_err2; d_at2 = d2;
      if (prev2) glitch++;
    end else if (crc_err2 || stuff_err2) glitch++;
    prev0 = sync0; prev1 = sync1; prev2 = sync2;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_of(input logic [63:0] pay, input int nb, input int cw,
                                         input logic [31:0] poly);
    logic [31:0] c, m;
    logic        fb;
    c = '0;
    m = (32'd1 << cw) - 32'd1;
    for (int i = 0; i < 8 * nb; i++) begin
      fb = c[cw-1] ^ pay[i];
      c  = ((c << 1) ^ (fb ? poly : 32'd0)) & m;
    end
    return c;
  endfunction

  task automatic set_line(input int line, input logic b);
    if (line == 0) bit_a = b;
    else bit_b = b;
  endtask

  task automatic idle(input int n);
    tick = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one tick; when spaced, a non-tick clk carrying the inverted bit goes first
  task automatic drive(input int line, input logic b, input bit spaced);
    if (spaced) begin
      tick = 1'b0;
      set_line(line, ~b);
      @(posedge clk);
      #1;
    end
    tick = 1'b1;
    set_line(line, b);
    @(posedge clk);
    if (pst >= 0 && pst < 128) edge_t[pst] = $time;
    #1;
    tick = 1'b0;
  endtask

  task automatic step(input int line, input logic b, input bit spaced, input int rst_at);
    if (pst == rst_at) rst_n = 1'b0;
    drive(line, b, spaced);
    if (pst == rst_at) begin
      @(negedge clk);
      check("rst sync", {63'd0, sync0}, 64'd0);
      check("rst d", d0, 64'd0);
      check("rst frame_cnt", {48'd0, fc0}, 64'd0);
      check("rst err_cnt", {48'd0, ec0}, 64'd0);
      check("rst flags", {62'd0, crc_err0, stuff_err0}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int line, input logic [63:0] pay, input int nb, input int cw,
                            input logic [31:0] poly, input int flip, input int bad_stuff,
                            input bit spaced, input int rst_at);
    logic [31:0] c;
    logic        b;
    int          idx;
    c   = crc_of(pay, nb, cw, poly);
    pst = 0;
    drive(line, 1'b1, spaced);
    for (int k = 0; k < nb + cw / 8; k++) begin
      for (int j = 0; j < 8; j++) begin
        idx = 8 * k + j;
        b   = (idx < 8 * nb) ? pay[idx] : c[cw-1-(idx-8*nb)];
        if (idx == flip) b = ~b;
        pst++;
        step(line, b, spaced, rst_at);
      end
      pst++;
      step(line, (k == bad_stuff) ? 1'b0 : 1'b1, spaced, rst_at);
    end
  endtask

  task automatic send_gap(input int line, input int n);
    for (int g = 0; g < n; g++) drive(line, 1'b0, 1'b0);
  endtask

  initial begin
    logic [63:0] p;
    int          base, end_tick;
    p = 64'h0123456789ABCDEF;
    //             pay                    gap flip bad sp  sy cr st  exp_d                  fc ec
    tbl[0]  = '{64'h0,                  9,  -1,  -1, 0,  1, 0, 0, 64'h0,                  1, 0};
    tbl[1]  = '{p,                      9,  -1,  -1, 0,  1, 0, 0, p,                      2, 0};
    tbl[2]  = '{p,                      9,  70,  -1, 0,  1, 1, 0, p,                      2, 1};
    tbl[3]  = '{p,                      9,  -1,   3, 0,  1, 0, 1, p,                      2, 2};
    tbl[4]  = '{64'hA5A5A5A55A5A5A5A,  12,  -1,  -1, 1,  1, 0, 0, 64'hA5A5A5A55A5A5A5A,  3, 2};
    tbl[5]  = '{64'h1122334455667788,   8,  -1,  -1, 0,  0, 0, 0, 64'hA5A5A5A55A5A5A5A,  3, 2};
    tbl[6]  = '{64'hFFFFFFFF00000000,   9,  -1,  -1, 0,  1, 0, 0, 64'hFFFFFFFF00000000,  4, 2};
    tbl[7]  = '{64'h8000000000000001,   9,  -1,  -1, 0,  1, 0, 0, 64'h8000000000000001,  5, 2};
    tbl[8]  = '{p,                      9,  -1,   9, 0,  1, 0, 1, 64'h8000000000000001,  5, 3};
    tbl[9]  = '{p,                     10,  10,  -1, 0,  1, 1, 0, 64'h8000000000000001,  5, 4};
    tbl[10] = '{p,                      9,  79,  -1, 1,  1, 1, 0, 64'h8000000000000001,  5, 5};

    idle(3);
    check("reset sync", {63'd0, sync0}, 64'd0);
    check("reset d", d0, 64'd0);
    check("reset frame_cnt", {48'd0, fc0}, 64'd0);
    check("reset err_cnt", {48'd0, ec0}, 64'd0);
    check("reset flags", {62'd0, crc_err0, stuff_err0}, 64'd0);
    rst_n = 1'b1;
    idle(2);

    for (int v = 0; v < 11; v++) begin
      base = n_sync0;
      send_gap(0, tbl[v].gap);
      send_frame(0, tbl[v].pay, 8, 16, 32'h1021, tbl[v].flip, tbl[v].bad_stuff, tbl[v].spaced, -1);
      idle(3);
      check($sformatf("v%0d sync count", v), 64'(n_sync0 - base), 64'(tbl[v].exp_sync));
      if (tbl[v].exp_sync) begin
        end_tick = (tbl[v].bad_stuff >= 0) ? 9 * (tbl[v].bad_stuff + 1) : 90;
        check($sformatf("v%0d sync delay", v), 64'(t_sync0 - edge_t[end_tick]), 64'd5);
        check($sformatf("v%0d crc_err", v), {63'd0, f_crc0}, 64'(tbl[v].exp_crc));
        check($sformatf("v%0d stuff_err", v), {63'd0, f_st0}, 64'(tbl[v].exp_stuff));
        check($sformatf("v%0d d at sync", v), d_at0, tbl[v].exp_d);
      end
      check($sformatf("v%0d d", v), d0, tbl[v].exp_d);
      check($sformatf("v%0d frame_cnt", v), {48'd0, fc0}, 64'(tbl[v].exp_fc));
      check($sformatf("v%0d err_cnt", v), {48'd0, ec0}, 64'(tbl[v].exp_ec));
      check($sformatf("v%0d d cnt2", v), d1, tbl[v].exp_d);
      check($sformatf("v%0d frame_cnt cnt2", v), {62'd0, fc1}, 64'(tbl[v].exp_fc % 4));
      check($sformatf("v%0d err_cnt cnt2", v), {62'd0, ec1},
            64'((tbl[v].exp_ec > 3) ? 3 : tbl[v].exp_ec));
    end
    check("cnt2 sync count", 64'(n_sync1), 64'(n_sync0));
    check("crc8 build idle", 64'(n_sync2), 64'd0);

    // reset at post-start tick 40, then the rest of the frame on the line, then a clean frame
    base = n_sync0;
    send_gap(0, 9);
    send_frame(0, p, 8, 16, 32'h1021, -1, -1, 1'b0, 40);
    idle(3);
    check("mid-reset no sync", 64'(n_sync0 - base), 64'd0);
    check("mid-reset d", d0, 64'd0);
    send_gap(0, 9);
    send_frame(0, p, 8, 16, 32'h1021, -1, -1, 1'b0, -1);
    idle(3);
    check("post-reset sync", 64'(n_sync0 - base), 64'd1);
    check("post-reset d", d0, p);
    check("post-reset frame_cnt", {48'd0, fc0}, 64'd1);
    check("post-reset err_cnt", {48'd0, ec0}, 64'd0);

    base = n_sync2;
    send_gap(1, 9);
    send_frame(1, 64'hDEADBEEF, 4, 8, 32'h07, -1, -1, 1'b0, -1);
    idle(3);
    check("crc8 sync count", 64'(n_sync2 - base), 64'd1);
    check("crc8 sync delay", 64'(t_sync2 - edge_t[45]), 64'd5);
    check("crc8 flags", {62'd0, f_crc2, f_st2}, 64'd0);
    check("crc8 d at sync", {32'd0, d_at2}, 64'hDEADBEEF);
    check("crc8 frame_cnt", {48'd0, fc2}, 64'd1);
    check("crc8 err_cnt", {48'd0, ec2}, 64'd0);

    check("flags outside sync / long sync", 64'(glitch), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
